// File: rtl/wb_machine_timer.sv
// RISC-V machine timer on a Wishbone classic data bus.
// Holds 64-bit mtime/mtimecmp, a prescaler and the level timer interrupt.
module wb_machine_timer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h2000_0000,
  parameter int          PRESCALE     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        irq_o
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        en;
  logic [15:0] pre;

  logic        hit;
  logic        req;
  logic        bad;
  logic        wr;
  logic        tick;
  logic [2:0]  idx;
  logic [31:0] wmask;
  logic [31:0] rdata;

  assign rty_o = 1'b0;
  assign idx   = adr_i[4:2];
  assign hit   = cyc_i & stb_i &
                 (adr_i[31:5] == BASE_ADDRESS[31:5]);
  // One response per request, then a forced idle cycle
  assign req   = hit & ~ack_o & ~err_o;
  assign bad   = (adr_i[1:0] != 2'b00) | (idx > 3'd4);
  assign wr    = req & ~bad & we_i & (|sel_i);
  assign tick  = en & (pre == PRE_MAX);
  assign wmask = {{8{sel_i[3]}}, {8{sel_i[2]}},
                  {8{sel_i[1]}}, {8{sel_i[0]}}};

  function automatic logic [31:0] merge(
    input logic [31:0] old
  );
    return (old & ~wmask) | (dat_i & wmask);
  endfunction

  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata = mtime[31:0];
      3'd1:    rdata = mtime[63:32];
      3'd2:    rdata = mtimecmp[31:0];
      3'd3:    rdata = mtimecmp[63:32];
      3'd4:    rdata = {31'b0, en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
      irq_o <= 1'b0;
    end else begin
      ack_o <= req & ~bad;
      err_o <= req & bad;
      dat_o <= (req & ~bad) ? rdata : '0;
      irq_o <= (mtime >= mtimecmp);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre <= '0;
    end else if (!en) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // A software write to either mtime half drops that edge's increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime <= '0;
    end else if (wr && idx == 3'd0) begin
      mtime[31:0] <= merge(mtime[31:0]);
    end else if (wr && idx == 3'd1) begin
      mtime[63:32] <= merge(mtime[63:32]);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp <= '1;
      en       <= 1'b1;
    end else begin
      if (wr && idx == 3'd2) begin
        mtimecmp[31:0] <= merge(mtimecmp[31:0]);
      end
      if (wr && idx == 3'd3) begin
        mtimecmp[63:32] <= merge(mtimecmp[63:32]);
      end
      if (wr && idx == 3'd4 && sel_i[0]) begin
        en <= dat_i[0];
      end
    end
  end

endmodule
